// File: rtl/tru_nibble_seq_if.sv
// tru_nibble_seq_if: start/busy/done handshake and operand/result bus for tru_nibble_seq
//   start, a_in, b_in, bin : request and operands (master -> slave)
//   busy, done             : handshake status (slave -> master)
//   d_out, bo, zero        : registered difference, borrow-out, zero flag (slave -> master)
interface tru_nibble_seq_if #(parameter int NIBBLES = 4);
    localparam int W = 4 * NIBBLES;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] d_out;
    logic         bo;
    logic         zero;
    modport master (output start, a_in, b_in, bin, input busy, done, d_out, bo, zero);
    modport slave (input start, a_in, b_in, bin, output busy, done, d_out, bo, zero);
endinterface

// File: rtl/tru_nibble_seq.sv
// tru_nibble_seq: nibble-serial W-bit subtractor D = A - B - bin sharing one tru_4bit slice
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : tru_nibble_seq_if slave (start/a_in/b_in/bin in; busy/done/d_out/bo/zero out)
// tru_4bit: 4-bit ripple subtractor slice (A - B - bin -> D, borrow-out bo)
module tru_4bit (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       bin,
    output logic [3:0] D,
    output logic       bo
);
    // The 5th bit of the widened difference is the borrow-out.
    assign {bo, D} = {1'b0, A} - {1'b0, B} - {4'b0, bin};
endmodule

module tru_nibble_seq #(parameter int NIBBLES = 4) (
    input logic             clk,
    input logic             rst,
    tru_nibble_seq_if.slave bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int CW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t        state, nxt;
    logic [W-1:0]  a_sh, b_sh, d_sh;
    logic          brw;
    logic [CW-1:0] cnt;
    logic [3:0]    d_nib;
    logic          bo_nib;
    logic [W+3:0]  d_cat;
    logic [W-1:0]  d_next;
    logic          last;
    tru_4bit slice (.A(a_sh[3:0]), .B(b_sh[3:0]), .bin(brw), .D(d_nib), .bo(bo_nib));
    // Concatenate then drop the low nibble so the shift also works when W == 4.
    assign d_cat  = {d_nib, d_sh};
    assign d_next = d_cat[W+3:4];
    assign last   = cnt == CW'(NIBBLES - 1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = bus.start ? RUN : IDLE;
            RUN:     nxt = last ? DONE : RUN;
            default: nxt = IDLE;
        endcase
    end
    always_comb begin
        bus.busy = state == RUN;
        bus.done = state == DONE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh      <= '0;
            b_sh      <= '0;
            d_sh      <= '0;
            brw       <= 1'b0;
            cnt       <= '0;
            bus.d_out <= '0;
            bus.bo    <= 1'b0;
            bus.zero  <= 1'b0;
        end else if (state == IDLE && bus.start) begin
            a_sh <= bus.a_in;
            b_sh <= bus.b_in;
            brw  <= bus.bin;
            cnt  <= '0;
        end else if (state == RUN) begin
            a_sh <= a_sh >> 4;
            b_sh <= b_sh >> 4;
            d_sh <= d_next;
            brw  <= bo_nib;
            cnt  <= cnt + 1'b1;
            if (last) begin
                bus.d_out <= d_next;
                bus.bo    <= bo_nib;
                bus.zero  <= d_next == '0;
            end
        end
    end
endmodule

// File: tb/tb_tru_nibble_seq.sv
// tb_tru_nibble_seq: directed self-checking bench for tru_nibble_seq (NIBBLES=4 and NIBBLES=1)
module tb_tru_nibble_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    always #5 clk = ~clk;
    tru_nibble_seq_if #(.NIBBLES(4)) bus4 ();
    tru_nibble_seq_if #(.NIBBLES(1)) bus1 ();
    tru_nibble_seq #(.NIBBLES(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
    tru_nibble_seq #(.NIBBLES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Issue one operation on the 4-nibble DUT and follow it through RUN, DONE and back to IDLE.
    task automatic op4(input logic [15:0] a, input logic [15:0] b, input logic bi,
                       input logic [15:0] ed, input logic eb, input logic ez);
        @(negedge clk);
        bus4.start = 1'b1; bus4.a_in = a; bus4.b_in = b; bus4.bin = bi;
        @(negedge clk);
        bus4.start = 1'b0;
        check("busy_run0", 32'(bus4.busy), 32'd1);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            check("busy_run", 32'(bus4.busy), 32'd1);
            check("done_run", 32'(bus4.done), 32'd0);
        end
        @(negedge clk);
        check("done_pulse", 32'(bus4.done), 32'd1);
        check("busy_done", 32'(bus4.busy), 32'd0);
        check("d_out", 32'(bus4.d_out), 32'(ed));
        check("bo", 32'(bus4.bo), 32'(eb));
        check("zero", 32'(bus4.zero), 32'(ez));
        @(negedge clk);
        check("done_clear", 32'(bus4.done), 32'd0);
        check("busy_idle", 32'(bus4.busy), 32'd0);
    endtask

    initial begin
        bus4.start = 1'b0; bus4.a_in = '0; bus4.b_in = '0; bus4.bin = 1'b0;
        bus1.start = 1'b0; bus1.a_in = '0; bus1.b_in = '0; bus1.bin = 1'b0;
        #12;
        check("rst_busy", 32'(bus4.busy), 32'd0);
        check("rst_done", 32'(bus4.done), 32'd0);
        check("rst_d", 32'(bus4.d_out), 32'd0);
        check("rst_bo", 32'(bus4.bo), 32'd0);
        check("rst_zero", 32'(bus4.zero), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        // Plain subtraction, full borrow ripple, and borrow-in giving zero.
        op4(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
        op4(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        op4(16'h8000, 16'h7FFF, 1'b1, 16'h0000, 1'b0, 1'b1);
        // Start held through RUN and DONE is ignored; start in the following IDLE cycle is taken.
        @(negedge clk);
        bus4.start = 1'b1; bus4.a_in = 16'h0050; bus4.b_in = 16'h0010; bus4.bin = 1'b0;
        @(negedge clk);
        bus4.a_in = 16'hFFFF; bus4.b_in = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_busy", 32'(bus4.busy), 32'd1);
        end
        @(negedge clk);
        check("t4_done", 32'(bus4.done), 32'd1);
        check("t4_d", 32'(bus4.d_out), 32'h0040);
        check("t4_bo", 32'(bus4.bo), 32'd0);
        @(negedge clk);
        check("t4_idle", 32'(bus4.busy), 32'd0);
        bus4.a_in = 16'h0003; bus4.b_in = 16'h0001;
        @(negedge clk);
        bus4.start = 1'b0;
        check("t4_restart", 32'(bus4.busy), 32'd1);
        check("t4_hold_d", 32'(bus4.d_out), 32'h0040);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            check("t4_hold_run", 32'(bus4.d_out), 32'h0040);
        end
        @(negedge clk);
        check("t4_done2", 32'(bus4.done), 32'd1);
        check("t4_d2", 32'(bus4.d_out), 32'h0002);
        // Asynchronous reset in the 2nd RUN cycle aborts with no done pulse.
        @(negedge clk);
        bus4.start = 1'b1; bus4.a_in = 16'h1111; bus4.b_in = 16'h0001;
        @(negedge clk);
        bus4.start = 1'b0;
        @(negedge clk);
        check("t5_busy_pre", 32'(bus4.busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t5_busy", 32'(bus4.busy), 32'd0);
        check("t5_d", 32'(bus4.d_out), 32'd0);
        check("t5_bo", 32'(bus4.bo), 32'd0);
        check("t5_zero", 32'(bus4.zero), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t5_no_done", 32'(bus4.done), 32'd0);
        end
        op4(16'h0003, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);
        // Single-nibble DUT with start held for back-to-back operations.
        @(negedge clk);
        bus1.start = 1'b1; bus1.a_in = 4'h3; bus1.b_in = 4'h5; bus1.bin = 1'b0;
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            check("n1_busy", 32'(bus1.busy), 32'd1);
            check("n1_nodone", 32'(bus1.done), 32'd0);
            @(negedge clk);
            check("n1_done", 32'(bus1.done), 32'd1);
            check("n1_d", 32'(bus1.d_out), 32'hE);
            check("n1_bo", 32'(bus1.bo), 32'd1);
            check("n1_zero", 32'(bus1.zero), 32'd0);
            @(negedge clk);
            check("n1_idle_busy", 32'(bus1.busy), 32'd0);
            check("n1_idle_done", 32'(bus1.done), 32'd0);
            if (n == 1) bus1.start = 1'b0;
        end
        @(negedge clk);
        check("n1_stays_idle", 32'(bus1.busy), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
